sparse_mult_frame_arbiter: RTL
==============================

// Module: sparse_mult_frame_arbiter
//
// PURPOSE
// Shares one sparse parity multiplier (FRAME_LEN words in, 1 word out per frame) between NUM_REQ streams.
// Grants are round-robin and frame-granular: a granted requester owns the multiplier input for exactly FRAME_LEN beats.
// Requester ID of each granted frame is queued in a tag FIFO and attached to the matching result word.
// Sits between the per-stream packers and the multiplier; downstream demuxes results by o_out_tag.
//
// PARAMETERS
// WIDTH      96  data word width (requester, multiplier and result buses)
// NUM_REQ    2   number of requesters, >=2
// FRAME_LEN  11  input beats per frame, must equal the multiplier input length, >=2
// TAG_DEPTH  4   frames in flight (granted, result not yet delivered), power of 2
//
// PORTS
// i_clock        in   1               clock
// i_reset        in   1               asynchronous reset, active-high
// i_req_data     in   NUM_REQ*WIDTH   requester r data at [r*WIDTH +: WIDTH]
// i_req_valid    in   NUM_REQ         per-requester valid
// o_req_ready    out  NUM_REQ         per-requester ready; at most one bit set
// o_mult_data    out  WIDTH           data to multiplier
// o_mult_valid   out  1               valid to multiplier
// i_mult_ready   in   1               multiplier input ready
// i_res_data     in   WIDTH           multiplier result
// i_res_valid    in   1               multiplier result valid
// o_res_ready    out  1               result ready to multiplier
// o_out_data     out  WIDTH           tagged result data (= i_res_data)
// o_out_tag      out  TW              requester ID, TW = max(1,$clog2(NUM_REQ))
// o_out_valid    out  1               tagged result valid
// i_out_ready    in   1               downstream ready
// o_busy         out  1               1 when in ST_BURST or tag FIFO non-empty
//
// BEHAVIOUR
// - All handshakes valid/ready; transfer when both high in same cycle. Valid may not depend on ready.
// - Reset (async): state=ST_IDLE, beat count=0, rr pointer=0, tag FIFO empty; all outputs 0.
// - FSM ST_IDLE: if tag FIFO not full and any i_req_valid, register grant = first valid requester
//   at/after rr pointer (wrapping), push grant to tag FIFO, go ST_BURST. Else stay. One idle cycle per frame.
// - FSM ST_BURST: o_mult_data/o_mult_valid = granted requester's data/valid; o_req_ready[grant] = i_mult_ready,
//   others 0. Beat count increments per transfer; on transfer with count==FRAME_LEN-1: count<=0,
//   rr pointer<=grant+1 (mod NUM_REQ), go ST_IDLE. Gaps in requester valid mid-frame are allowed; grant held.
// - In ST_IDLE o_req_ready=0 and o_mult_valid=0 (no beat passes during arbitration).
// - Result path combinational: o_out_valid = i_res_valid & ~tag_empty; o_res_ready = i_out_ready & ~tag_empty;
//   o_out_tag = tag FIFO head. Pop on o_out_valid & i_out_ready.
// - Result with tag FIFO empty: held off (o_res_ready=0), never dropped or mis-tagged.
// - Tag FIFO full (TAG_DEPTH frames outstanding): no new grant; current burst completes normally.
// - Simultaneous grant push and result pop in one cycle: both happen, occupancy unchanged.
// - Single requester valid: granted repeatedly, back-to-back frames separated by one idle cycle.
// - Reset mid-frame: partial frame abandoned; upstream/multiplier must be reset with the same i_reset.
//
// TESTING
// 1. NUM_REQ=2, both valid continuously, all readies 1 -> grants 0,1,0,1; 11 beats each, 1 idle cycle
//    between; result tags 0,1,0,1.
// 2. Only req 1 valid, 3 frames -> three grants to 1; o_req_ready[0] stays 0; tags 1,1,1.
// 3. i_out_ready=0, results held by multiplier, 4 frames granted -> 5th grant blocked until one pop,
//    granted the cycle after the pop.
// 4. Req 0 drops valid for 5 cycles at beat 6 -> no beat from req 1 passes; frame completes at beat 11, then req 1 granted.
// 5. i_mult_ready toggles 1/0 every cycle -> exactly 11 transfers per frame, o_req_ready mirrors i_mult_ready for grant only.
// 6. Assert i_reset asynchronously at beat 4 of a frame -> outputs 0 immediately, tag FIFO empty; first post-reset grant to req 0.

Source files
------------

// File: rtl/sparse_mult_frame_arbiter.sv
// sparse_mult_frame_arbiter: frame-granular round-robin share of one multiplier input,
// with a tag FIFO that labels each result word with the requester that fed its frame.
module sparse_mult_frame_arbiter #(
  parameter int WIDTH = 96,
  parameter int NUM_REQ = 2,
  parameter int FRAME_LEN = 11,
  parameter int TAG_DEPTH = 4,
  localparam int TW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_mult_data,
  output logic                     o_mult_valid,
  input  logic                     i_mult_ready,
  input  logic [WIDTH-1:0]         i_res_data,
  input  logic                     i_res_valid,
  output logic                     o_res_ready,
  output logic [WIDTH-1:0]         o_out_data,
  output logic [TW-1:0]            o_out_tag,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_busy
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(FRAME_LEN);
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic [TW:0] cand;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_q [TAG_DEPTH];
  logic [AW:0] wr_q, rd_q, occ;
  logic [WIDTH-1:0] words [NUM_REQ];
  logic burst, empty, full, push, pop, xfer, last;
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) words[r] = i_req_data[r*WIDTH +: WIDTH];
  end
  // Walk offsets high to low so the requester closest to the pointer wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (TW+1)'(i);
      cand = (cand >= (TW+1)'(NUM_REQ)) ? cand - (TW+1)'(NUM_REQ) : cand;
      pick = i_req_valid[cand[TW-1:0]] ? cand[TW-1:0] : pick;
    end
  end
  assign occ   = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (occ == (AW+1)'(TAG_DEPTH));
  assign burst = (state_q == ST_BURST);
  assign push  = !burst && !full && (|i_req_valid);
  assign xfer  = burst && i_req_valid[grant_q] && i_mult_ready;
  assign last  = xfer && (cnt_q == CW'(FRAME_LEN - 1));
  assign pop   = o_out_valid && i_out_ready;
  always_comb begin
    state_d = burst ? (last ? ST_IDLE : ST_BURST) : (push ? ST_BURST : ST_IDLE);
    grant_d = push ? pick : grant_q;
    cnt_d   = last ? '0 : (xfer ? cnt_q + 1'b1 : cnt_q);
    rr_d    = last ? ((grant_q == TW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1) : rr_q;
  end
  always_comb begin
    o_mult_valid = burst && i_req_valid[grant_q];
    o_mult_data  = burst ? words[grant_q] : '0;
    o_req_ready  = burst ? (NUM_REQ'(i_mult_ready) << grant_q) : '0;
    o_out_valid  = i_res_valid && !empty;
    o_res_ready  = i_out_ready && !empty;
    o_out_tag    = empty ? '0 : tag_q[rd_q[AW-1:0]];
    o_out_data   = i_res_data;
    o_busy       = burst || !empty;
  end
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (push) tag_q[wr_q[AW-1:0]] <= pick;
      wr_q    <= wr_q + (AW+1)'(push);
      rd_q    <= rd_q + (AW+1)'(pop);
    end
  end
endmodule
